phase_sequencer: RTL and testbench

Parametrised successor to the core's timing generator. It derives the sub-cycle phase counter `q`, the phase-high flag `p` / `phi2_out` and the machine-cycle step counter `r` from the single fast clock `fclk`, replacing the separate `sfclk` domain. It adds an RDY stall, a restart request from the cycle generator, and a cycle-end strobe to instruction decode. It sits between the cycle generator and instruction decode in the 65C02 core.

---
 rtl/timing_pkg.sv | 18 +
 rtl/phase_counter.sv | 60 ++++++
 rtl/phase_sequencer.sv | 102 ++++++++++
 tb/tb_phase_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared defaults and phase typedef for the 65C02 timing generator.
package timing_pkg;

   // Width of a phase index; a single-bit counter is the floor even for two phases.
   function automatic int qw_of(input int phases);
      return ($clog2(phases) < 1) ? 1 : $clog2(phases);
   endfunction

   localparam int TC_Q_PHASES = 4;
   localparam int TC_P_RISE   = 2;
   localparam int TC_P_FALL   = 4;
   localparam int TC_R_WIDTH  = 4;
   localparam int TC_R_LAST   = 15;
   localparam int TC_QW       = qw_of(TC_Q_PHASES);

   typedef logic [TC_QW-1:0] tc_phase_t;

endpackage

// File: rtl/phase_counter.sv
// Free-running sub-cycle phase counter with registered phase-high decode
// and the cycle-end indication for the step logic above it.
module phase_counter
   import timing_pkg::*;
#(
   parameter int Q_PHASES = TC_Q_PHASES,
   parameter int P_RISE   = TC_P_RISE,
   parameter int P_FALL   = TC_P_FALL,
   parameter int QW       = qw_of(Q_PHASES)
) (
   input  logic          fclk,
   input  logic          reset,
   output logic [QW-1:0] q,
   output logic          p,
   output logic          ce
);

   localparam logic [QW-1:0] LAST_PHASE = QW'(Q_PHASES - 1);
   localparam logic          P_RESET    = (P_RISE == 0);

   logic [QW-1:0] phase_d, phase_q;
   logic          p_d, p_q;

   function automatic logic in_window(input logic [QW-1:0] ph);
      int unsigned v;
      v = 32'(ph);
      return (v >= 32'(P_RISE)) && (v < 32'(P_FALL));
   endfunction

   // ce marks the edge on which the phase leaves its last value.
   assign ce = (phase_q == LAST_PHASE);

   always_comb begin
      phase_d = ce ? '0 : phase_q + QW'(1);
      // p is decoded from the next phase so p and q move on the same edge.
      p_d     = in_window(phase_d);
   end

   // NOTE: state flops use non-blocking assignments and reset asynchronously.
   always_ff @(posedge fclk or posedge reset) begin
      if (reset) begin
         phase_q <= '0;
         p_q     <= P_RESET;
      end else begin
         phase_q <= phase_d;
         p_q     <= p_d;
      end
   end

   assign q = phase_q;
   assign p = p_q;

   if (Q_PHASES < 2) begin : g_bad_q_phases
      $error("phase_counter: Q_PHASES must be at least 2");
   end
   if (P_RISE < 0 || P_RISE >= P_FALL || P_FALL > Q_PHASES) begin : g_bad_p_window
      $error("phase_counter: need 0 <= P_RISE < P_FALL <= Q_PHASES");
   end

endmodule

// File: rtl/phase_sequencer.sv
// Machine-cycle step counter with RDY stall, restart request and cycle-end
// strobes, driven from the single fast clock via phase_counter.
module phase_sequencer
   import timing_pkg::*;
#(
   parameter int Q_PHASES = TC_Q_PHASES,
   parameter int P_RISE   = TC_P_RISE,
   parameter int P_FALL   = TC_P_FALL,
   parameter int R_WIDTH  = TC_R_WIDTH,
   parameter int R_LAST   = TC_R_LAST,
   localparam int QW      = qw_of(Q_PHASES)
) (
   input  logic               fclk,
   input  logic               reset,
   input  logic               rdy,
   input  logic               cg_to_tc,
   output logic [QW-1:0]      q,
   output logic               p,
   output logic               phi2_out,
   output logic [R_WIDTH-1:0] r,
   output logic               tc_to_id,
   output logic               r_wrap,
   output logic               stalled
);

   logic               ce;
   logic [R_WIDTH-1:0] r_d, r_q;
   logic               pending_d, pending_q;
   logic               tc_d, tc_q;
   logic               wrap_d, wrap_q;
   logic               stalled_d, stalled_q;

   phase_counter #(
      .Q_PHASES (Q_PHASES),
      .P_RISE   (P_RISE),
      .P_FALL   (P_FALL),
      .QW       (QW)
   ) u_phase_counter (
      .fclk  (fclk),
      .reset (reset),
      .q     (q),
      .p     (p),
      .ce    (ce)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      r_d       = r_q;
      pending_d = pending_q | cg_to_tc;
      tc_d      = 1'b0;
      wrap_d    = 1'b0;
      stalled_d = stalled_q;
      if (ce) begin
         if (rdy) begin
            tc_d      = 1'b1;
            stalled_d = 1'b0;
            // A restart requested in the final phase still lands on this edge.
            if (pending_q || cg_to_tc) begin
               r_d       = '0;
               pending_d = 1'b0;
            end else if (r_q == R_WIDTH'(R_LAST)) begin
               r_d    = '0;
               wrap_d = 1'b1;
            end else begin
               r_d = r_q + R_WIDTH'(1);
            end
         end else begin
            stalled_d = 1'b1;
         end
      end
   end

   always_ff @(posedge fclk or posedge reset) begin
      if (reset) begin
         r_q       <= '0;
         pending_q <= 1'b0;
         tc_q      <= 1'b0;
         wrap_q    <= 1'b0;
         stalled_q <= 1'b0;
      end else begin
         r_q       <= r_d;
         pending_q <= pending_d;
         tc_q      <= tc_d;
         wrap_q    <= wrap_d;
         stalled_q <= stalled_d;
      end
   end

   assign phi2_out = p;
   assign r        = r_q;
   assign tc_to_id = tc_q;
   assign r_wrap   = wrap_q;
   assign stalled  = stalled_q;

   if (R_WIDTH < 1 || R_WIDTH > 30) begin : g_bad_r_width
      $error("phase_sequencer: R_WIDTH out of range");
   end
   if (R_LAST < 0 || R_LAST > (1 << R_WIDTH) - 1) begin : g_bad_r_last
      $error("phase_sequencer: R_LAST must fit in R_WIDTH bits");
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench: default-parameter sequencer plus a Q_PHASES=6 variant.
module tb_phase_sequencer;

   logic       fclk;
   logic       reset_a, rdy_a, cg_a;
   logic [1:0] q_a;
   logic       p_a, phi2_a, tc_a, wrap_a, stalled_a;
   logic [3:0] r_a;

   logic       reset_b, rdy_b, cg_b;
   logic [2:0] q_b;
   logic       p_b, phi2_b, tc_b, wrap_b, stalled_b;
   logic [2:0] r_b;

   int checks = 0;
   int errors = 0;

   phase_sequencer dut_a (
      .fclk     (fclk),
      .reset    (reset_a),
      .rdy      (rdy_a),
      .cg_to_tc (cg_a),
      .q        (q_a),
      .p        (p_a),
      .phi2_out (phi2_a),
      .r        (r_a),
      .tc_to_id (tc_a),
      .r_wrap   (wrap_a),
      .stalled  (stalled_a)
   );

   phase_sequencer #(
      .Q_PHASES (6),
      .P_RISE   (1),
      .P_FALL   (3),
      .R_WIDTH  (3),
      .R_LAST   (5)
   ) dut_b (
      .fclk     (fclk),
      .reset    (reset_b),
      .rdy      (rdy_b),
      .cg_to_tc (cg_b),
      .q        (q_b),
      .p        (p_b),
      .phi2_out (phi2_b),
      .r        (r_b),
      .tc_to_id (tc_b),
      .r_wrap   (wrap_b),
      .stalled  (stalled_b)
   );

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   // One fclk edge on dut_a with the given inputs held across it.
   task automatic step(input logic rdy_v, input logic cg_v);
      rdy_a = rdy_v;
      cg_a  = cg_v;
      @(posedge fclk);
      #1;
      rdy_a = 1'b1;
      cg_a  = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n * 4) step(1'b1, 1'b0);
   endtask

   task automatic expect_a(input string name, input logic [3:0] r_exp, input logic tc_exp,
                           input logic wrap_exp, input logic st_exp);
      checks++;
      if (r_a !== r_exp || tc_a !== tc_exp || wrap_a !== wrap_exp || stalled_a !== st_exp) begin
         errors++;
         $display("FAIL %s: r=%0d tc=%b wrap=%b stalled=%b, want r=%0d tc=%b wrap=%b stalled=%b",
                  name, r_a, tc_a, wrap_a, stalled_a, r_exp, tc_exp, wrap_exp, st_exp);
      end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({q_a, p_a, phi2_a, r_a, tc_a, wrap_a, stalled_a} !== 11'd0) begin
         errors++;
         $display("FAIL reset_a: q=%0d p=%b phi2=%b r=%0d tc=%b wrap=%b stalled=%b, want all 0",
                  q_a, p_a, phi2_a, r_a, tc_a, wrap_a, stalled_a);
      end
      checks++;
      if ({q_b, p_b, r_b, tc_b, wrap_b, stalled_b} !== 10'd0) begin
         errors++;
         $display("FAIL reset_b: q=%0d p=%b r=%0d tc=%b wrap=%b stalled=%b, want all 0",
                  q_b, p_b, r_b, tc_b, wrap_b, stalled_b);
      end
      @(negedge fclk);
      @(negedge fclk);
      reset_a = 1'b0;
   endtask

   task automatic test_free_run;
      logic [1:0] exp_q;
      logic [3:0] exp_r;
      logic       exp_p;
      int         wraps = 0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge fclk);
         #1;
         exp_q = 2'(k % 4);
         exp_p = (k % 4) >= 2;
         exp_r = 4'((k / 4) % 16);
         if (wrap_a === 1'b1) wraps++;
         checks++;
         if (q_a !== exp_q || p_a !== exp_p || phi2_a !== exp_p) begin
            errors++;
            $display("FAIL free_run_qp edge %0d: q=%0d p=%b phi2=%b, want q=%0d p=%b",
                     k, q_a, p_a, phi2_a, exp_q, exp_p);
         end
         expect_a($sformatf("free_run edge %0d", k), exp_r, (k % 4) == 0, k == 64, 1'b0);
      end
      checks++;
      if (wraps != 1) begin
         errors++;
         $display("FAIL free_run_wrap_count: got %0d, want 1", wraps);
      end
   endtask

   // Enters with q=0, r=4.
   task automatic test_stall;
      cycles(1);
      expect_a("stall_setup", 4'd5, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      for (int c = 0; c < 2; c++) begin
         step(1'b0, 1'b0);
         expect_a($sformatf("stall_ce%0d", c), 4'd5, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            expect_a($sformatf("stall_hold%0d_%0d", c, i), 4'd5, 1'b0, 1'b0, 1'b1);
         end
      end
      step(1'b1, 1'b0);
      expect_a("stall_release", 4'd6, 1'b1, 1'b0, 1'b0);
      // rdy low outside the final phase must not stall
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      expect_a("rdy_ignored", 4'd7, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_restart;
      cycles(2);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      expect_a("restart_pending", 4'd9, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0);
      expect_a("restart_ce", 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_restart_stalled;
      cycles(9);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      expect_a("restart_stalled_ce", 4'd9, 1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      expect_a("restart_stalled_done", 4'd0, 1'b1, 1'b0, 1'b0);
      cycles(1);
      expect_a("restart_stalled_after", 4'd1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      expect_a("collapse_ce", 4'd0, 1'b1, 1'b0, 1'b0);
      cycles(1);
      expect_a("collapse_after", 4'd1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_restart_at_wrap;
      cycles(14);
      expect_a("wrap_setup", 4'd15, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      expect_a("restart_at_wrap", 4'd0, 1'b1, 1'b0, 1'b0);
      cycles(1);
      expect_a("restart_at_wrap_after", 4'd1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset;
      cycles(6);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      checks++;
      if (q_a !== 2'd2 || r_a !== 4'd7) begin
         errors++;
         $display("FAIL areset_setup: q=%0d r=%0d, want q=2 r=7", q_a, r_a);
      end
      #2 reset_a = 1'b1;
      #1;
      checks++;
      if ({q_a, p_a, phi2_a, r_a, tc_a, wrap_a, stalled_a} !== 11'd0) begin
         errors++;
         $display("FAIL areset_immediate: q=%0d p=%b phi2=%b r=%0d tc=%b wrap=%b stalled=%b, want all 0",
                  q_a, p_a, phi2_a, r_a, tc_a, wrap_a, stalled_a);
      end
      @(negedge fclk);
      @(negedge fclk);
      reset_a = 1'b0;
      @(posedge fclk);
      #1;
      checks++;
      if (q_a !== 2'd1 || r_a !== 4'd0 || tc_a !== 1'b0) begin
         errors++;
         $display("FAIL areset_first_edge: q=%0d r=%0d tc=%b, want q=1 r=0 tc=0", q_a, r_a, tc_a);
      end
      repeat (2) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      expect_a("areset_first_ce", 4'd1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_params;
      logic [2:0] exp_q, exp_r;
      logic       exp_p;
      int         wraps = 0;
      @(negedge fclk);
      reset_b = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge fclk);
         #1;
         exp_q = 3'(k % 6);
         exp_p = (k % 6 == 1) || (k % 6 == 2);
         exp_r = 3'((k / 6) % 6);
         if (wrap_b === 1'b1) wraps++;
         checks++;
         if (q_b !== exp_q || p_b !== exp_p || phi2_b !== exp_p || r_b !== exp_r ||
             tc_b !== ((k % 6) == 0) || wrap_b !== ((k % 36) == 0) || stalled_b !== 1'b0) begin
            errors++;
            $display("FAIL params edge %0d: q=%0d p=%b r=%0d tc=%b wrap=%b, want q=%0d p=%b r=%0d tc=%b wrap=%b",
                     k, q_b, p_b, r_b, tc_b, wrap_b, exp_q, exp_p, exp_r, (k % 6) == 0, (k % 36) == 0);
         end
      end
      checks++;
      if (wraps != 2) begin
         errors++;
         $display("FAIL params_wrap_count: got %0d, want 2", wraps);
      end
   endtask

   initial begin
      reset_a = 1'b1;
      rdy_a   = 1'b1;
      cg_a    = 1'b0;
      reset_b = 1'b1;
      rdy_b   = 1'b1;
      cg_b    = 1'b0;
      test_reset();
      test_free_run();
      test_stall();
      test_restart();
      test_restart_stalled();
      test_back_to_back();
      test_restart_at_wrap();
      test_async_reset();
      test_params();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
